// File: rtl/nvme_io_cmd_issue.sv
// Issues NVMe I/O command ids {req_id, action_id, sq_id} with per-action in-order req_id and credit limit.
// Optional NVME_ISSUE_STATS_EN adds stat_issued/stat_stall counters.
module nvme_io_cmd_issue #(
  parameter int ACTION_ID_BITS = 4,
  parameter int QUEUE_ID_BITS  = 4,
  parameter int REQ_ID_BITS    = 8,
  parameter int TRACK_NUM      = 16
) (
  input  logic                                              axi_aclk,
  input  logic                                              axi_areset,
  input  logic                                              track_init,
  input  logic                                              req_valid,
  output logic                                              req_ready,
  input  logic [ACTION_ID_BITS-1:0]                         req_action_id,
  input  logic [QUEUE_ID_BITS-1:0]                          req_sq_id,
  input  logic                                              req_admin,
  output logic                                              cmd_valid,
  input  logic                                              cmd_ready,
  output logic [REQ_ID_BITS+ACTION_ID_BITS+QUEUE_ID_BITS-1:0] cmd_id,
  input  logic                                              cpl_valid,
  input  logic [ACTION_ID_BITS-1:0]                         cpl_action_id,
  output logic [2**ACTION_ID_BITS-1:0]                      busy,
  output logic                                              credit_err,
  input  logic                                              credit_err_clear
`ifdef NVME_ISSUE_STATS_EN
  ,
  output logic [31:0]                                       stat_issued,
  output logic [31:0]                                       stat_stall
`endif
);

  localparam int NUM_ACT  = 2**ACTION_ID_BITS;
  localparam int CNT_BITS = $clog2(TRACK_NUM+1);
  localparam logic [CNT_BITS-1:0]    TRACK_MAX = CNT_BITS'(TRACK_NUM);
  localparam logic [REQ_ID_BITS-1:0] REQ_LAST  = REQ_ID_BITS'(TRACK_NUM-1);

  typedef enum logic [1:0] {IDLE, CHECK, WAIT_CREDIT, ISSUE} state_t;

  state_t                    state_q, state_d;
  logic [ACTION_ID_BITS-1:0] aid_q;
  logic [QUEUE_ID_BITS-1:0]  sq_q;
  logic                      adm_q;
  logic [REQ_ID_BITS-1:0]    next_req [NUM_ACT];
  logic [CNT_BITS-1:0]       outst    [NUM_ACT];
  logic                      issue_go;
  logic                      cpl_hit;
  logic                      cpl_zero;
  logic [REQ_ID_BITS-1:0]    req_id_sel;
  logic [NUM_ACT-1:0]        inc_vec;
  logic [NUM_ACT-1:0]        dec_vec;

  always_comb begin
    state_d   = state_q;
    issue_go  = 1'b0;
    req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = track_init;
        if (req_valid && track_init) state_d = CHECK;
      end
      CHECK: begin
        if (adm_q || (outst[aid_q] < TRACK_MAX)) begin
          state_d  = ISSUE;
          issue_go = 1'b1;
        end else begin
          state_d = WAIT_CREDIT;
        end
      end
      WAIT_CREDIT: begin
        if (outst[aid_q] < TRACK_MAX) begin
          state_d  = ISSUE;
          issue_go = 1'b1;
        end
      end
      ISSUE: begin
        if (cmd_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A credit return against an empty counter is flagged and otherwise ignored.
  always_comb begin
    cpl_zero   = cpl_valid && (outst[cpl_action_id] == '0);
    cpl_hit    = cpl_valid && (outst[cpl_action_id] != '0);
    req_id_sel = adm_q ? '0 : next_req[aid_q];
    inc_vec    = '0;
    dec_vec    = '0;
    busy       = '0;
    for (int i = 0; i < NUM_ACT; i++) begin
      inc_vec[i] = issue_go && !adm_q && (aid_q == ACTION_ID_BITS'(i));
      dec_vec[i] = cpl_hit && (cpl_action_id == ACTION_ID_BITS'(i));
      busy[i]    = (outst[i] != '0);
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state_q   <= IDLE;
      aid_q     <= '0;
      sq_q      <= '0;
      adm_q     <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_id    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid && track_init) begin
        aid_q <= req_action_id;
        sq_q  <= req_sq_id;
        adm_q <= req_admin;
      end
      if (issue_go) begin
        cmd_valid <= 1'b1;
        cmd_id    <= {req_id_sel, aid_q, sq_q};
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      for (int i = 0; i < NUM_ACT; i++) begin
        next_req[i] <= '0;
        outst[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ACT; i++) begin
        if (inc_vec[i]) next_req[i] <= (next_req[i] == REQ_LAST) ? '0 : next_req[i] + 1'b1;
        if (inc_vec[i] && !dec_vec[i]) outst[i] <= outst[i] + 1'b1;
        else if (dec_vec[i] && !inc_vec[i]) outst[i] <= outst[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) credit_err <= 1'b0;
    else if (cpl_zero) credit_err <= 1'b1;
    else if (credit_err_clear) credit_err <= 1'b0;
  end

`ifdef NVME_ISSUE_STATS_EN
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (cmd_valid && cmd_ready) stat_issued <= stat_issued + 32'd1;
      if (state_q == WAIT_CREDIT) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule
